// File: rtl/osd_hex_multi_writer.sv
// Round-robin arbiter that renders NCH debug values as uppercase ASCII hex fields into one text-buffer port.
// Optional build macro OSD_HEX_PREFIX_EN prepends "0x" to every field.
//
// state | meaning
// IDLE  | waiting for a pending channel; grants one and captures its value/origin
// WRITE | emitting one character per clock at line*COLS+col+k
module osd_hex_multi_writer #(
  parameter int NCH    = 4,
  parameter int DIGITS = 2,
  parameter int COLS   = 32,
  parameter int ADDR_W = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          req,
  input  logic [NCH*4*DIGITS-1:0] value,
  input  logic [NCH*4-1:0]        linea,
  input  logic [NCH*5-1:0]        columna,
  output logic [NCH-1:0]          ack,
  output logic                    busy,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [7:0]              wr_data,
  output logic                    wr_en
);

  localparam int VW  = 4 * DIGITS;
`ifdef OSD_HEX_PREFIX_EN
  localparam int PFX = 2;
`else
  localparam int PFX = 0;
`endif
  localparam int FLEN = DIGITS + PFX;
  localparam int PW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW4  = ADDR_W + 4;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t          state;
  logic [NCH-1:0]  pend;
  logic [PW-1:0]   rr_ptr;
  logic [VW-1:0]   cap_val;
  logic [3:0]      cap_line;
  logic [4:0]      cap_col;
  logic [3:0]      k;

  logic            gnt_vld;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   cand;
  logic [3:0]      nib;
  logic [7:0]      char_k;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // first pending channel at or after rr_ptr, wrapping
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NCH);
      if (!gnt_vld && pend[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // character k of the field: optional "0x", then nibbles MSB first
  always_comb begin
    nib    = 4'(cap_val >> (4 * (FLEN - 1 - int'(k))));
    char_k = hex_char(nib);
    if (PFX != 0 && k == 4'd0)
      char_k = 8'h30;
    else if (PFX != 0 && k == 4'd1)
      char_k = 8'h78;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pend     <= '0;
      rr_ptr   <= '0;
      ack      <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      k        <= '0;
      cap_val  <= '0;
      cap_line <= '0;
      cap_col  <= '0;
    end else begin
      ack   <= '0;
      wr_en <= 1'b0;
      pend  <= pend | req;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            // a request seen at the grant edge re-arms the granted channel
            pend     <= (pend & ~(NCH'(1) << gnt_idx)) | req;
            ack      <= NCH'(1) << gnt_idx;
            cap_val  <= value[gnt_idx*VW +: VW];
            cap_line <= linea[gnt_idx*4 +: 4];
            cap_col  <= columna[gnt_idx*5 +: 5];
            rr_ptr   <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
            k        <= '0;
            state    <= WRITE;
          end
        end
        WRITE: begin
          wr_en   <= 1'b1;
          wr_addr <= ADDR_W'(AW4'(cap_line) * AW4'(COLS) + AW4'(cap_col) + AW4'(k));
          wr_data <= char_k;
          k       <= k + 4'd1;
          if (k == 4'(FLEN - 1))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_osd_hex_multi_writer.sv
// Self-checking bench for osd_hex_multi_writer: directed scenarios plus randomized traffic
// compared against a transaction-level reference model (honours OSD_HEX_PREFIX_EN).
module tb_osd_hex_multi_writer;
  localparam int NCH = 4, DIGITS = 2, COLS = 32, ADDR_W = 7, VW = 4 * DIGITS;
`ifdef OSD_HEX_PREFIX_EN
  localparam int PFX = 2;
`else
  localparam int PFX = 0;
`endif
  localparam int L = DIGITS + PFX;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       req;
  logic [NCH*VW-1:0]    value;
  logic [NCH*4-1:0]     linea;
  logic [NCH*5-1:0]     columna;
  logic [NCH-1:0]       ack;
  logic                 busy;
  logic [ADDR_W-1:0]    wr_addr;
  logic [7:0]           wr_data;
  logic                 wr_en;

  osd_hex_multi_writer #(.NCH(NCH), .DIGITS(DIGITS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req(req), .value(value), .linea(linea), .columna(columna),
    .ack(ack), .busy(busy), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en));

  always #5 clk = ~clk;

  typedef struct {int cyc; int addr; int data;} wr_t;
  typedef struct {int cyc; int ch;} ak_t;

  int  n_chk = 0, n_fail = 0, cyc = 0;
  wr_t act_w[$], exp_w[$];
  ak_t act_a[$], exp_a[$];
  logic [NCH-1:0] m_pend;
  int  m_ptr, m_free;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) act_w.push_back('{cyc, int'(wr_addr), int'(wr_data)});
    if (ack !== '0) begin
      n_chk++;
      if ($countones(ack) != 1) begin
        n_fail++;
        $display("FAIL ack_onehot: ack=%b, required exactly one bit", ack);
      end
      for (int i = 0; i < NCH; i++) if (ack[i]) act_a.push_back('{cyc, i});
    end
  end

  // reference: character j of a field and its wrapped buffer address
  function automatic logic [7:0] exp_char(input int val, input int j);
    int nib;
    if (j < PFX) return (j == 0) ? 8'h30 : 8'h78;
    nib = (val >> (4 * (DIGITS - 1 - (j - PFX)))) & 15;
    return (nib < 10) ? 8'(48 + nib) : 8'(55 + nib);
  endfunction

  function automatic int exp_addr(input int line, input int col, input int j);
    return (line * COLS + col + j) % (1 << ADDR_W);
  endfunction

  // reference model at transaction level: one step per clock edge, inputs as sampled at that edge
  task automatic model_step();
    int e, g;
    bit found;
    e = cyc + 1;
    found = 0;
    g = 0;
    if (e >= m_free && m_pend != 0) begin
      for (int i = 0; i < NCH; i++)
        if (!found && m_pend[(m_ptr + i) % NCH]) begin
          found = 1;
          g = (m_ptr + i) % NCH;
        end
      exp_a.push_back('{e, g});
      for (int j = 0; j < L; j++)
        exp_w.push_back('{e + 1 + j,
                          exp_addr(int'(linea[g*4 +: 4]), int'(columna[g*5 +: 5]), j),
                          int'(exp_char(int'(value[g*VW +: VW]), j))});
      m_free = e + L + 1;
      m_ptr  = (g + 1) % NCH;
      m_pend[g] = 1'b0;
    end
    m_pend = m_pend | req;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input int val, input int line, input int col);
    value[ch*VW +: VW]  = VW'(val);
    linea[ch*4 +: 4]    = 4'(line);
    columna[ch*5 +: 5]  = 5'(col);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    tick();
    tick();
    reset = 1'b0;
    act_w.delete(); act_a.delete(); exp_w.delete(); exp_a.delete();
    m_pend = '0; m_ptr = 0; m_free = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '1;
    value = {$urandom, $urandom};
    tick(); tick();
    @(negedge clk);
    n_chk += 5;
    if (ack !== '0)    begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    if (wr_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", wr_addr); end
    if (wr_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", wr_data); end
    act_w.delete(); act_a.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    req = '0;
    repeat (6) tick();
    n_chk++;
    if (act_w.size() != 0 || act_a.size() != 0) begin
      n_fail++;
      $display("FAIL reset_no_activity: writes=%0d acks=%0d want 0/0", act_w.size(), act_a.size());
    end
  endtask

  // single field, checked cycle by cycle from the request edge
  task automatic test_single();
    logic [NCH-1:0] e_ack;
    logic e_en, e_busy;
    do_reset();
    set_ch(0, 'h3C, 1, 8);
    req = 4'b0001;
    tick();
    req = '0;
    for (int n = 0; n <= L + 2; n++) begin
      @(negedge clk);
      e_ack  = (n == 1) ? 4'b0001 : 4'b0000;
      e_en   = (n >= 2 && n <= L + 1);
      e_busy = (n >= 1 && n <= L);
      n_chk += 3;
      if (ack !== e_ack)   begin n_fail++; $display("FAIL single_ack c%0d: got %b want %b", n, ack, e_ack); end
      if (wr_en !== e_en)  begin n_fail++; $display("FAIL single_wr_en c%0d: got %b want %b", n, wr_en, e_en); end
      if (busy !== e_busy) begin n_fail++; $display("FAIL single_busy c%0d: got %b want %b", n, busy, e_busy); end
      if (e_en) begin
        n_chk += 2;
        if (int'(wr_addr) != exp_addr(1, 8, n - 2)) begin
          n_fail++; $display("FAIL single_addr c%0d: got %0d want %0d", n, wr_addr, exp_addr(1, 8, n - 2));
        end
        if (wr_data !== exp_char('h3C, n - 2)) begin
          n_fail++; $display("FAIL single_data c%0d: got %h want %h", n, wr_data, exp_char('h3C, n - 2));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int vals[4] = '{'h00, 'h10, 'hAB, 'hFF};
    int idx;
    do_reset();
    for (int c = 0; c < NCH; c++) set_ch(c, vals[c], c, 4 * c);
    req = 4'b1111;
    tick();
    req = '0;
    repeat (4 * (L + 2) + 4) tick();
    n_chk += 2;
    if (act_a.size() != 4) begin n_fail++; $display("FAIL b2b_ack_count: got %0d want 4", act_a.size()); end
    if (act_w.size() != 4 * L) begin n_fail++; $display("FAIL b2b_write_count: got %0d want %0d", act_w.size(), 4 * L); end
    for (int i = 0; i < act_a.size() && i < 4; i++) begin
      n_chk++;
      if (act_a[i].ch != i) begin n_fail++; $display("FAIL b2b_order %0d: got ch%0d want ch%0d", i, act_a[i].ch, i); end
    end
    for (int f = 0; f < 4; f++)
      for (int j = 0; j < L; j++) begin
        idx = f * L + j;
        if (idx < act_w.size()) begin
          n_chk += 2;
          if (act_w[idx].addr != exp_addr(f, 4 * f, j) || act_w[idx].data != int'(exp_char(vals[f], j))) begin
            n_fail++;
            $display("FAIL b2b_write f%0d j%0d: got %0d/%h want %0d/%h", f, j, act_w[idx].addr,
                     act_w[idx].data, exp_addr(f, 4 * f, j), exp_char(vals[f], j));
          end
          if (idx > 0 && act_w[idx].cyc - act_w[idx-1].cyc != ((j == 0) ? 2 : 1)) begin
            n_fail++;
            $display("FAIL b2b_spacing %0d: got gap %0d want %0d", idx, act_w[idx].cyc - act_w[idx-1].cyc,
                     (j == 0) ? 2 : 1);
          end
        end
      end
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_end: busy=%b want 0", busy); end
  endtask

  task automatic test_fairness();
    do_reset();
    set_ch(1, 'h5A, 2, 0);
    set_ch(2, 'hC3, 2, 16);
    req = 4'b0110;
    repeat (5 * (L + 2)) tick();
    req = '0;
    repeat (3 * (L + 2)) tick();
    n_chk++;
    if (act_a.size() < 4) begin n_fail++; $display("FAIL fair_count: got %0d grants want >=4", act_a.size()); end
    for (int i = 0; i < act_a.size(); i++) begin
      n_chk++;
      if (act_a[i].ch != ((i % 2 == 0) ? 1 : 2)) begin
        n_fail++;
        $display("FAIL fair_alternate %0d: got ch%0d want ch%0d", i, act_a[i].ch, (i % 2 == 0) ? 1 : 2);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    set_ch(3, 'hE5, 3, 31);
    req = 4'b1000;
    tick();
    req = '0;
    repeat (L + 4) tick();
    n_chk++;
    if (act_w.size() != L) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", act_w.size(), L); end
    for (int j = 0; j < act_w.size() && j < L; j++) begin
      n_chk++;
      if (act_w[j].addr != exp_addr(3, 31, j) || act_w[j].data != int'(exp_char('hE5, j))) begin
        n_fail++;
        $display("FAIL wrap_write %0d: got %0d/%h want %0d/%h", j, act_w[j].addr, act_w[j].data,
                 exp_addr(3, 31, j), exp_char('hE5, j));
      end
    end
  endtask

  task automatic test_freeze();
    do_reset();
    set_ch(0, 'h12, 0, 3);
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    tick();
    set_ch(0, 'h34, 0, 3);
    repeat (L + 3) tick();
    n_chk++;
    if (act_w.size() != L) begin n_fail++; $display("FAIL freeze_count: got %0d want %0d", act_w.size(), L); end
    for (int j = 0; j < act_w.size() && j < L; j++) begin
      n_chk++;
      if (act_w[j].data != int'(exp_char('h12, j))) begin
        n_fail++; $display("FAIL freeze_old %0d: got %h want %h", j, act_w[j].data, exp_char('h12, j));
      end
    end
    act_w.delete();
    req = 4'b0001;
    tick();
    req = '0;
    repeat (L + 4) tick();
    n_chk++;
    if (act_w.size() != L) begin n_fail++; $display("FAIL freeze_new_count: got %0d want %0d", act_w.size(), L); end
    for (int j = 0; j < act_w.size() && j < L; j++) begin
      n_chk++;
      if (act_w[j].data != int'(exp_char('h34, j))) begin
        n_fail++; $display("FAIL freeze_new %0d: got %h want %h", j, act_w[j].data, exp_char('h34, j));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_ch(0, 'hA7, 2, 5);
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    tick();
    n_chk++;
    if (wr_en !== 1'b1) begin n_fail++; $display("FAIL midrst_first_digit: wr_en=%b want 1", wr_en); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk += 2;
    if (wr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_en: got %b want 0", wr_en); end
    if (busy !== 1'b0)  begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    act_w.delete(); act_a.delete();
    repeat (6) tick();
    n_chk++;
    if (act_w.size() != 0) begin n_fail++; $display("FAIL midrst_no_writes: got %0d want 0", act_w.size()); end
    req = 4'b0001;
    tick();
    req = '0;
    repeat (L + 4) tick();
    n_chk += 2;
    if (act_a.size() != 1 || (act_a.size() == 1 && act_a[0].ch != 0)) begin
      n_fail++; $display("FAIL midrst_restart_ack: got %0d grants want one on ch0", act_a.size());
    end
    if (act_w.size() != L) begin n_fail++; $display("FAIL midrst_restart_count: got %0d want %0d", act_w.size(), L); end
    for (int j = 0; j < act_w.size() && j < L; j++) begin
      n_chk++;
      if (act_w[j].addr != exp_addr(2, 5, j) || act_w[j].data != int'(exp_char('hA7, j))) begin
        n_fail++;
        $display("FAIL midrst_restart_write %0d: got %0d/%h want %0d/%h", j, act_w[j].addr,
                 act_w[j].data, exp_addr(2, 5, j), exp_char('hA7, j));
      end
    end
  endtask

`ifdef OSD_HEX_PREFIX_EN
  task automatic test_prefix();
    int lit[4] = '{'h30, 'h78, 'h37, 'h46};
    do_reset();
    set_ch(0, 'h7F, 1, 8);
    req = 4'b0001;
    tick();
    req = '0;
    repeat (L + 4) tick();
    n_chk++;
    if (act_w.size() != 4) begin n_fail++; $display("FAIL prefix_count: got %0d want 4", act_w.size()); end
    for (int j = 0; j < act_w.size() && j < 4; j++) begin
      n_chk++;
      if (act_w[j].addr != 40 + j || act_w[j].data != lit[j]) begin
        n_fail++;
        $display("FAIL prefix_write %0d: got %0d/%h want %0d/%h", j, act_w[j].addr, act_w[j].data, 40 + j, lit[j]);
      end
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 400; t++) begin
      for (int c = 0; c < NCH; c++) begin
        req[c] = ($urandom_range(0, 3) == 0);
        set_ch(c, int'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 31)));
      end
      model_step();
      tick();
    end
    req = '0;
    repeat (60) begin
      model_step();
      tick();
    end
    tick();
    n_chk += 2;
    if (act_a.size() != exp_a.size()) begin
      n_fail++; $display("FAIL rand_ack_count: got %0d want %0d", act_a.size(), exp_a.size());
    end
    if (act_w.size() != exp_w.size()) begin
      n_fail++; $display("FAIL rand_write_count: got %0d want %0d", act_w.size(), exp_w.size());
    end
    for (int i = 0; i < act_a.size() && i < exp_a.size(); i++) begin
      n_chk++;
      if (act_a[i].cyc != exp_a[i].cyc || act_a[i].ch != exp_a[i].ch) begin
        n_fail++;
        $display("FAIL rand_ack %0d: got ch%0d@%0d want ch%0d@%0d", i, act_a[i].ch, act_a[i].cyc,
                 exp_a[i].ch, exp_a[i].cyc);
      end
    end
    for (int i = 0; i < act_w.size() && i < exp_w.size(); i++) begin
      n_chk++;
      if (act_w[i].cyc != exp_w[i].cyc || act_w[i].addr != exp_w[i].addr || act_w[i].data != exp_w[i].data) begin
        n_fail++;
        $display("FAIL rand_write %0d: got %0d/%h@%0d want %0d/%h@%0d", i, act_w[i].addr, act_w[i].data,
                 act_w[i].cyc, exp_w[i].addr, exp_w[i].data, exp_w[i].cyc);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    value = '0;
    linea = '0;
    columna = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_wrap();
    test_freeze();
    test_reset_mid();
`ifdef OSD_HEX_PREFIX_EN
    test_prefix();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
